sng_lfsr: RTL and testbench
===========================

SNG_LFSR -- requirements
Module: sng_lfsr

Interface
REQ-001 Parameter WIDTH, 8, binary operand width; stream length L = 2^WIDTH - 1 bits.
REQ-002 Parameter TAPS, 8'hB8, Fibonacci LFSR feedback mask; default is x^8+x^6+x^5+x^4+1, maximal length.
REQ-003 Parameter SEED, 1, LFSR load value; SEED==0 SHALL be replaced by 1.
REQ-004 clk  input  1  clock, rising-edge active.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request to convert value; sampled only in IDLE.
REQ-007 value  input  WIDTH  unsigned binary operand, probability value/L.
REQ-008 out_ready  input  1  downstream (relu stage) accepts current bit.
REQ-009 out  output  1  stochastic bitstream bit.
REQ-010 out_valid  output  1  out carries a valid bit.
REQ-011 busy  output  1  conversion in progress.
REQ-012 done  output  1  one-cycle pulse after last bit transferred.

Function
REQ-013 FSM states: IDLE, RUN; busy = (state==RUN); out_valid = (state==RUN).
REQ-014 IDLE & start at edge k: at edge k, state->RUN, val_q<=value, lfsr<=SEED, cnt<=0.
REQ-015 In RUN, out = (lfsr <= val_q), combinational from registers; in IDLE, out = 0.
REQ-016 Transfer = out_valid & out_ready; on transfer, lfsr advances one LFSR step and cnt increments by 1.
REQ-017 No transfer (out_ready=0): lfsr, cnt, val_q, out held; out_valid stays 1.
REQ-018 LFSR SHALL never reach 0 and SHALL visit every value 1..L exactly once per run.
REQ-019 Exactness: ones in a run = val_q exactly (value 0 -> none, value L -> all).
REQ-020 Transfer with cnt==L-1: state->IDLE, cnt->0, done<=1 for next cycle only.
REQ-021 cnt width WIDTH bits; no wrap inside a run, since terminal count is L-1.
REQ-022 start while RUN ignored; value changes during RUN SHALL NOT affect the stream.
REQ-023 start high in the done cycle (state IDLE) SHALL be accepted; back-to-back runs with no gap beyond the done cycle.
REQ-024 done and out_valid are never high in the same cycle.

Reset
REQ-025 rst_n low at any time, including mid-run: state=IDLE, lfsr=SEED, cnt=0, val_q=0, done=0, out=0, out_valid=0, busy=0, immediately and asynchronously.
REQ-026 After rst_n deasserts, no stream until a new start; an aborted run is not resumed.

Verification (WIDTH=8, SEED=1, L=255)
REQ-027 value=100, out_ready=1, start pulse at edge k -> out_valid high cycles k+1..k+255, exactly 100 ones, done high only in cycle k+256.
REQ-028 value=0 -> 255 valid bits, all 0; value=255 -> 255 valid bits, all 1; done after each run.
REQ-029 value=37, out_ready random 50% -> out and lfsr stable while out_ready=0, exactly 37 ones over 255 transfers, done one cycle after the 255th transfer.
REQ-030 start pulsed with value=200 mid-run of value=10 -> ignored; the run still yields 10 ones.
REQ-031 rst_n low at transfer 120 -> all outputs 0 asynchronously; a new start with value=50 yields 50 ones from lfsr=1.
REQ-032 start held high through done -> second run starts in the done cycle; each run yields the correct ones count.

Source files
------------

// File: rtl/sng_lfsr_if.sv
// sng_lfsr_if: request/stream bundle for the stochastic number generator; master drives start/value/out_ready, slave returns out/out_valid/busy/done
interface sng_lfsr_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] value;
  logic             out_ready;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;
  modport master (output start, value, out_ready, input out, out_valid, busy, done);
  modport slave  (input start, value, out_ready, output out, out_valid, busy, done);
endinterface

// File: rtl/sng_lfsr.sv
// sng_lfsr: converts a WIDTH-bit value into a 2^WIDTH-1 bit stochastic stream (ones == value) using a maximal Fibonacci LFSR; ports clk, rst_n (async active-low), bus (sng_lfsr_if.slave)
module sng_lfsr #(
  parameter int             WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic      clk,
  input  logic      rst_n,
  sng_lfsr_if.slave bus
);
  localparam logic [WIDTH-1:0] SEED_V = (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;
  localparam logic [WIDTH-1:0] LAST   = {{(WIDTH-1){1'b1}}, 1'b0};
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             done_q, done_d;
  logic             run, xfer;
  assign run           = (state_q == RUN);
  assign xfer          = run & bus.out_ready;
  assign bus.out_valid = run;
  assign bus.busy      = run;
  assign bus.done      = done_q;
  // The LFSR walks every nonzero value once, so comparing against val_q yields exactly val_q ones
  assign bus.out       = run & (lfsr_q <= val_q);
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    done_d  = 1'b0;
    if (!run && bus.start) begin
      state_d = RUN;
      val_d   = bus.value;
      lfsr_d  = SEED_V;
      cnt_d   = '0;
    end else if (xfer) begin
      lfsr_d  = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
      cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      state_d = (cnt_q == LAST) ? IDLE : RUN;
      done_d  = (cnt_q == LAST);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_V;
      cnt_q   <= '0;
      val_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_sng_lfsr.sv
// tb_sng_lfsr: randomized scoreboard bench for sng_lfsr against a stream-level reference model
module tb_sng_lfsr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sng_lfsr_if #(.WIDTH(8)) bus ();
  sng_lfsr #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int   n_chk = 0;
  int   n_fail = 0;
  int   seq [255];
  logic exp_q [$];
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  logic stalled = 1'b0;
  logic held = 1'b0;
  int   cur_val = 0;
  int   ones = 0;
  int   xfers = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Monitor: compare outputs with the model for this cycle, then advance the model for the coming edge
  always @(negedge clk) begin
    logic nd;
    if (rst_n) begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_busy));
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("done", 32'(bus.done), 32'(m_done));
      if (!m_busy) chk("out_idle", 32'(bus.out), 0);
      if (stalled && m_busy) chk("stall_hold", 32'(bus.out), 32'(held));
      stalled = m_busy && !bus.out_ready;
      held = bus.out;
      nd = 1'b0;
      if (m_busy && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL scoreboard_empty: got transfer expected none");
        end else chk("bit", 32'(bus.out), 32'(exp_q.pop_front()));
        ones += int'(bus.out);
        xfers++;
        if (xfers == 255) begin
          chk("ones", ones, cur_val);
          m_busy = 1'b0;
          nd = 1'b1;
        end
      end else if (!m_busy && bus.start) begin
        m_busy = 1'b1;
        cur_val = int'(bus.value);
        ones = 0;
        xfers = 0;
        for (int i = 0; i < 255; i++) exp_q.push_back(seq[i] <= cur_val);
      end
      m_done = nd;
    end
  end
  task automatic start_run(input int v);
    @(posedge clk); #1;
    bus.value = 8'(v);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.value = 8'($urandom_range(255));
  endtask
  task automatic wait_idle(input int pct, input int mid_start, input int abort_at, input logic hold);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(99) < pct);
      bus.start = hold || (c == mid_start);
      if (c == mid_start) bus.value = 8'd200;
      if (abort_at > 0 && xfers >= abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_out", 32'(bus.out), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        exp_q.delete();
        m_busy = 1'b0;
        m_done = 1'b0;
        stalled = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      if (!m_busy) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL timeout: got busy expected idle within 3000 cycles");
  endtask
  initial begin
    int x;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      seq[i] = x;
      x = ((x << 1) & 255) | ($countones(x & 'hB8) & 1);
    end
    bus.start = 1'b0;
    bus.value = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("reset_out", 32'(bus.out), 0);
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    start_run(100); wait_idle(100, -1, 0, 1'b0);
    start_run(0);   wait_idle(100, -1, 0, 1'b0);
    start_run(255); wait_idle(100, -1, 0, 1'b0);
    start_run(37);  wait_idle(50, -1, 0, 1'b0);
    start_run(10);  wait_idle(70, 50, 0, 1'b0);
    start_run(90);  wait_idle(100, -1, 120, 1'b0);
    repeat (5) @(posedge clk);
    start_run(50);  wait_idle(60, -1, 0, 1'b0);
    @(posedge clk); #1;
    bus.value = 8'd20;
    bus.start = 1'b1;
    @(posedge clk); #1;
    wait_idle(100, -1, 0, 1'b1);
    bus.value = 8'd60;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.value = 8'($urandom_range(255));
    wait_idle(80, -1, 0, 1'b0);
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
